// File: rtl/spram_loader_pkg.sv
// Shared types and constants for the SPRAM byte-stream loader/dumper.
package spram_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE,
    WAIT_W,
    READ,
    WAIT_R,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/spram_loader.sv
// Byte-stream initiator for the single-port RAM bus: packs bytes into words
// on load, unpacks words into bytes on dump.
module spram_loader
  import spram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned LEN_W  = 17
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              dir_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [7:0]        out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              sel_o,
  output logic              wr_en_o,
  output logic [3:0]        wr_mask_o,
  output logic [ADDR_W-1:0] address_o,
  output logic [31:0]       data_o,
  input  logic [31:0]       data_i,
  input  logic              ack_i
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [31:0]       shreg_q;
  logic [1:0]        lane_q;

  logic in_hs, out_hs, last_byte;

  assign in_hs     = (state == FILL) && in_valid_i;
  assign out_hs    = (state == DRAIN) && out_ready_i;
  // Word boundary: fourth lane handled, or this byte is the last of the transfer.
  assign last_byte = (lane_q == 2'(BYTES_PER_WORD - 1)) || (rem_q == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = (len_i == '0) ? DONE : (dir_i ? READ : FILL);
      FILL:    if (in_hs && last_byte) state_nx = WRITE;
      WRITE:   state_nx = WAIT_W;
      WAIT_W:  if (ack_i) state_nx = (rem_q == '0) ? DONE : FILL;
      READ:    state_nx = WAIT_R;
      WAIT_R:  if (ack_i) state_nx = DRAIN;
      DRAIN:   if (out_hs && last_byte) state_nx = (rem_q == LEN_W'(1)) ? DONE : READ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Packer and unpacker share the shift register and the lane counter.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      addr_q  <= '0;
      rem_q   <= '0;
      shreg_q <= '0;
      lane_q  <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          addr_q  <= base_addr_i;
          rem_q   <= len_i;
          shreg_q <= '0;
          lane_q  <= '0;
        end
        FILL: if (in_hs) begin
          shreg_q[{lane_q, 3'b000} +: 8] <= in_data_i;
          lane_q <= lane_q + 2'd1;
          rem_q  <= rem_q - LEN_W'(1);
        end
        WAIT_W: if (ack_i) begin
          addr_q  <= addr_q + ADDR_W'(1);
          shreg_q <= '0;
          lane_q  <= '0;
        end
        WAIT_R: if (ack_i) begin
          shreg_q <= data_i;
          lane_q  <= '0;
        end
        DRAIN: if (out_hs) begin
          shreg_q <= {8'h00, shreg_q[31:8]};
          lane_q  <= lane_q + 2'd1;
          rem_q   <= rem_q - LEN_W'(1);
          if (last_byte) addr_q <= addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // lane_q wraps to 0 after a full word, so 0 in WRITE means four lanes.
  always_comb begin
    wr_mask_o = '0;
    if (state == WRITE) begin
      case (lane_q)
        2'd0:    wr_mask_o = 4'b1111;
        2'd1:    wr_mask_o = 4'b0001;
        2'd2:    wr_mask_o = 4'b0011;
        default: wr_mask_o = 4'b0111;
      endcase
    end
  end

  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign in_ready_o  = (state == FILL);
  assign out_valid_o = (state == DRAIN);
  assign out_data_o  = (state == DRAIN) ? shreg_q[7:0] : '0;
  assign sel_o       = (state == WRITE) || (state == READ);
  assign wr_en_o     = (state == WRITE);
  assign address_o   = addr_q;
  assign data_o      = (state == WRITE) ? shreg_q : '0;

endmodule

// File: doc/spram_loader.md
# spram_loader

Byte-stream initiator for the single-port RAM bus: the requester side of the `sel/wr_en/wr_mask/address/data/ack` interface. In load mode it packs an incoming byte stream little-endian into 32-bit words and writes them to consecutive word addresses. In dump mode it reads consecutive words and emits their bytes on an outgoing stream. It sits between the UART/boot path and the SPRAM, and is used for program loading and memory readback.

## Interface
Parameters:
- `ADDR_W`, default 15: word-address width of the RAM bus.
- `LEN_W`, default 17: byte-count width; covers 128 KiB.

Ports:
- `clk` in 1: single clock.
- `reset_n_i` in 1: synchronous, active-low reset.
- `start_i` in 1: start-command strobe; sampled only in IDLE.
- `dir_i` in 1: 0 = load (stream→RAM), 1 = dump (RAM→stream); sampled with `start_i`.
- `base_addr_i` in ADDR_W: first word address; sampled with `start_i`.
- `len_i` in LEN_W: byte count; sampled with `start_i`.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle completion pulse.
- `in_data_i` in 8, `in_valid_i` in 1, `in_ready_o` out 1: load byte stream.
- `out_data_o` out 8, `out_valid_o` out 1, `out_ready_i` in 1: dump byte stream.
- `sel_o` out 1: RAM access request.
- `wr_en_o` out 1: RAM write enable.
- `wr_mask_o` out 4: RAM byte lane enables.
- `address_o` out ADDR_W: RAM word address.
- `data_o` out 32: RAM write data.
- `data_i` in 32: RAM read data.
- `ack_i` in 1: RAM acknowledge.

## Operation
- States: IDLE, FILL, WRITE, WAIT_W, READ, WAIT_R, DRAIN, DONE.
- IDLE → on `start_i`:
  - `len_i==0` → DONE.
  - `dir_i==0` → FILL.
  - `dir_i==1` → READ.
  - `start_i` in any other state is ignored.
- FILL:
  - `in_ready_o=1`.
  - Each handshake places the byte in lane `k` (k = 0..3, first byte in lane 0) and decrements the remaining count.
  - After 4 bytes, or when the remaining count reaches 0, go to WRITE.
- WRITE:
  - One cycle with `sel_o=1` and `wr_en_o=1`.
  - `wr_mask_o` has one bit per collected lane (partial final word: 1→4'b0001, 2→4'b0011, 3→4'b0111).
  - Unfilled lanes of `data_o` are 0.
  - Next state is WAIT_W.
- WAIT_W:
  - `sel_o=0`; wait for `ack_i`.
  - On ack: address increments; go to FILL, or to DONE if the remaining count is 0.
- READ: one cycle with `sel_o=1`, `wr_en_o=0`, `wr_mask_o=0`.
- WAIT_R: on `ack_i`, capture `data_i` into the shift register, then go to DRAIN.
- DRAIN:
  - `out_valid_o=1`; `out_data_o` is lane 0 of the shift register.
  - Each handshake shifts right 8 bits and decrements the count.
  - After 4 bytes or count 0: address increments, then go to READ or DONE.
- DONE: `done_o=1` for one cycle, then IDLE.
- Address wraps modulo 2^ADDR_W (0x7FFF+1 → 0x0000).
- `sel_o` is never high for two consecutive cycles. Exactly one RAM access is issued per word.
- Reset (any state): everything returns to IDLE, and a partial word or in-flight access is discarded. An `ack_i` arriving after reset is ignored.

## Timing
- Reset value 0 on all outputs: `busy_o`, `done_o`, `in_ready_o`, `out_valid_o`, `out_data_o`, `sel_o`, `wr_en_o`, `wr_mask_o`, `address_o`, `data_o`.
- All outputs are registered, or decoded directly from state/registers (no input→output combinational paths).
- `start_i` at edge t:
  - `busy_o` high from cycle t+1.
  - For length 0, `done_o` high in cycle t+1.
- Load: if the final byte of a word is accepted at edge k, then `sel_o` is high in cycle k+1, the nominal `ack_i` is in cycle k+2, and `in_ready_o` is high again (or `done_o` is high) in cycle k+3.
- Dump: `sel_o` in cycle r, `ack_i` in r+1, first `out_valid_o` in r+2.
- Ack latency is unbounded; the FSM holds in WAIT_* and all outputs stay stable.
- `out_data_o` is held stable while `out_valid_o && !out_ready_i`.

## Structure
- `spram_loader_pkg`: `state_t` enum and lane-count constant (`BYTES_PER_WORD = 4`).
- Single module; no sub-module. The byte packer and byte unpacker share one 32-bit shift register and one 2-bit lane counter.

## Test plan
- The bench responder acks one cycle after `sel_o` and returns registered data.
- Load 8 bytes 0x01..0x08, base 0x0010: writes 0x0010←0x04030201 and 0x0011←0x08070605, both with mask 4'hF; one `done_o` pulse.
- Load 6 bytes 0x01..0x06, base 0x0020: second write is addr 0x0021, data 0x00000605, mask 4'b0011.
- Dump 6 bytes from 0x0020 with random `out_ready_i`: stream 01,02,03,04,05,06; exactly 2 `sel_o` pulses, all with `wr_en_o=0`; data stable under backpressure.
- Load 8 bytes at base 0x7FFF: addresses 0x7FFF then 0x0000.
- `len_i=0`: `done_o` in the cycle after start and no `sel_o`. A `start_i` pulsed while busy has no effect.
- Drop `reset_n_i` during WAIT_W with a responder that delays ack 3 cycles: all outputs 0 in the next cycle; the late ack is ignored; a following 4-byte load completes normally.
